// File: rtl/hdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hdb_pkg
//  Purpose  : Shared symbol codes and parameter limits for the HDBn encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package hdb_pkg;

    // Symbol classes carried through the delay line and presented on sym_type
    typedef enum logic [1:0] {
        HDB3_0 = 2'b00,   // zero, no pulse
        HDB3_1 = 2'b01,   // data mark (AMI pulse)
        HDB3_B = 2'b10,   // balancing pulse, obeys AMI alternation
        HDB3_V = 2'b11    // violation pulse, repeats previous polarity
    } hdb_sym_e;

    // Legal range of the zero-run substitution length
    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

    // Marks and B pulses both alternate polarity relative to the last pulse
    function automatic logic is_alt_pulse(input hdb_sym_e sym);
        return (sym == HDB3_1) || (sym == HDB3_B);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdbn_polarity.sv
`default_nettype none
// ============================================================================
//  Module   : hdbn_polarity
//  Purpose  : Polarity assignment for HDBn symbols. Tracks the polarity of
//             the last emitted pulse and drives registered code_p/code_n and
//             the symbol class of the emitted symbol.
//  Revision : 1.0 - initial release
// ============================================================================
module hdbn_polarity
    import hdb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_en,
    input  hdb_sym_e i_sym,
    output logic     o_code_p,
    output logic     o_code_n,
    output hdb_sym_e o_sym
);

    // 1 = last pulse was positive; reset treats the line as last-negative
    logic r_last_pol;
    logic r_code_p;
    logic r_code_n;
    hdb_sym_e r_sym;

    logic w_pulse_p;
    logic w_pulse_n;
    logic w_next_pol;

    // Pulse polarity for the symbol leaving the delay line
    always_comb begin
        w_pulse_p  = 1'b0;
        w_pulse_n  = 1'b0;
        w_next_pol = r_last_pol;
        if (is_alt_pulse(i_sym)) begin
            // AMI rule: opposite of the previous pulse, then remember it
            w_pulse_p  = ~r_last_pol;
            w_pulse_n  = r_last_pol;
            w_next_pol = ~r_last_pol;
        end else if (i_sym == HDB3_V) begin
            // Violation: same polarity as the previous pulse, history unchanged
            w_pulse_p  = r_last_pol;
            w_pulse_n  = ~r_last_pol;
        end
    end

    // Output and polarity-history registers; everything holds on stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_pol <= 1'b0;
            r_code_p   <= 1'b0;
            r_code_n   <= 1'b0;
            r_sym      <= HDB3_0;
        end else if (i_en) begin
            r_last_pol <= w_next_pol;
            r_code_p   <= w_pulse_p;
            r_code_n   <= w_pulse_n;
            r_sym      <= i_sym;
        end
    end

    assign o_code_p = r_code_p;
    assign o_code_n = r_code_n;
    assign o_sym    = r_sym;

endmodule
`default_nettype wire

// File: rtl/hdbn_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : hdbn_encoder
//  Purpose  : Parametrised HDBn line encoder. NRZ input bits are classified,
//             runs of N zeros are replaced by 0..0V or B0..0V so successive
//             violations alternate, and the result is polarity-assigned onto
//             code_p/code_n after an N-symbol look-back delay line.
//  Options  : HDBN_DEBUG_EN - adds test_add_v / test_add_b strobe outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module hdbn_encoder
    import hdb_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       data_in,
    output logic       out_valid,
    output logic       code_p,
    output logic       code_n,
    output logic [1:0] sym_type
`ifdef HDBN_DEBUG_EN
    ,
    output logic       test_add_v,
    output logic       test_add_b
`endif
);

    // Counter width shared by the zero-run counter and the fill counter
    localparam int                 c_cnt_w     = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_zero_last = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_fill_full = c_cnt_w'(N);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    // Input-stage state
    logic [c_cnt_w-1:0] r_zcnt;     // consecutive zeros since last mark or V
    logic               r_par;      // odd number of marks since last V
    logic [c_cnt_w-1:0] r_fill;     // accepted symbols since reset, saturating
    logic               r_out_valid;

    // Delay line: slot 0 newest, slot N-1 oldest
    hdb_sym_e r_dl [N];

    logic [c_cnt_w-1:0] w_zcnt_nxt;
    logic               w_par_nxt;
    hdb_sym_e           w_new_sym;
    logic               w_retag_b;
    hdb_sym_e           w_emit_sym;
    hdb_sym_e           w_out_sym;

    // Classify the incoming bit and decide on a 0..0V / B0..0V substitution
    always_comb begin
        w_new_sym  = HDB3_0;
        w_retag_b  = 1'b0;
        w_zcnt_nxt = r_zcnt + c_cnt_one;
        w_par_nxt  = r_par;
        if (data_in) begin
            w_new_sym  = HDB3_1;
            w_zcnt_nxt = '0;
            w_par_nxt  = ~r_par;
        end else if (r_zcnt == c_zero_last) begin
            // This zero completes a run of N: it becomes V. With an even
            // pulse count since the last V, the first zero of the run
            // becomes B so that this V has the opposite sign to the last V.
            w_new_sym  = HDB3_V;
            w_retag_b  = ~r_par;
            w_zcnt_nxt = '0;
            w_par_nxt  = 1'b0;
        end
    end

    // Zero-run counter and pulse parity advance only on accepted edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zcnt <= '0;
            r_par  <= 1'b0;
        end else if (in_valid) begin
            r_zcnt <= w_zcnt_nxt;
            r_par  <= w_par_nxt;
        end
    end

    // Look-back delay line; the B retag targets the post-shift oldest slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_dl[i] <= HDB3_0;
            end
        end else if (in_valid) begin
            r_dl[0] <= w_new_sym;
            for (int i = 1; i < N; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
            // The first zero of the run sits in slot N-2 before the shift,
            // so after this edge it occupies slot N-1; overriding here means
            // the retag and the shift can never race.
            if (w_retag_b) begin
                r_dl[N-1] <= HDB3_B;
            end
        end
    end

    assign w_emit_sym = r_dl[N-1];

    // Fill counter gates out_valid until the delay line holds real symbols
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid && (r_fill == c_fill_full);
            if (in_valid && (r_fill != c_fill_full)) begin
                r_fill <= r_fill + c_cnt_one;
            end
        end
    end

    hdbn_polarity u_polarity (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (in_valid),
        .i_sym    (w_emit_sym),
        .o_code_p (code_p),
        .o_code_n (code_n),
        .o_sym    (w_out_sym)
    );

    assign out_valid = r_out_valid;
    assign sym_type  = w_out_sym;

`ifdef HDBN_DEBUG_EN
    logic r_add_v;
    logic r_add_b;

    // Debug strobes registered alongside the line outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_add_v <= 1'b0;
            r_add_b <= 1'b0;
        end else if (in_valid) begin
            r_add_v <= (w_emit_sym == HDB3_V);
            r_add_b <= (w_emit_sym == HDB3_B);
        end
    end

    assign test_add_v = r_add_v;
    assign test_add_b = r_add_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdbn_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hdbn_encoder
//  Purpose  : Self-checking bench for hdbn_encoder. Two instances (N=4 and
//             N=3) receive identical stimulus; each is compared every cycle
//             against a list-based reference model of the encoding rules,
//             and the directed scenarios are also compared against fixed
//             symbol tables.
//  Options  : HDBN_DEBUG_EN - also checks test_add_v / test_add_b.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hdbn_encoder;
    import hdb_pkg::*;

    localparam int c_depth = 8192;
    localparam int c_logsz = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic       data_in;
    logic       ov [2];
    logic       cp [2];
    logic       cn [2];
    logic [1:0] st [2];
`ifdef HDBN_DEBUG_EN
    logic       tav [2];
    logic       tab [2];
`endif

    hdbn_encoder #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov[0]), .code_p(cp[0]), .code_n(cn[0]), .sym_type(st[0])
`ifdef HDBN_DEBUG_EN
        , .test_add_v(tav[0]), .test_add_b(tab[0])
`endif
    );

    hdbn_encoder #(.N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .out_valid(ov[1]), .code_p(cp[1]), .code_n(cn[1]), .sym_type(st[1])
`ifdef HDBN_DEBUG_EN
        , .test_add_v(tav[1]), .test_add_b(tab[1])
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: full symbol list since reset, retagged in place
    int         mn  [2];
    int         acc [2];
    int         zc  [2];
    bit         par [2];
    bit         lp  [2];
    logic [1:0] sq  [2][c_depth];
    logic       ev  [2];
    logic       ep  [2];
    logic       en  [2];
    logic [1:0] es  [2];
`ifdef HDBN_DEBUG_EN
    logic       etv [2];
    logic       etb [2];
`endif

    // Log of {code_p, code_n, sym_type} on out_valid cycles
    logic [3:0] lg  [2][c_logsz];
    int         lgn [2];

    task automatic chk(input string tag, input int u, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s N=%0d observed=%b expected=%b", tag, mn[u], obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            acc[u] = 0; zc[u] = 0; par[u] = 0; lp[u] = 0;
            ev[u] = 0; ep[u] = 0; en[u] = 0; es[u] = 2'b00;
`ifdef HDBN_DEBUG_EN
            etv[u] = 0; etb[u] = 0;
`endif
        end
    endtask

    task automatic model_step(input bit v, input bit d);
        logic [1:0] s;
        for (int u = 0; u < 2; u++) begin
            if (!v) begin
                ev[u] = 0;
            end else begin
                if (d) begin
                    sq[u][acc[u]] = HDB3_1;
                    zc[u] = 0;
                    par[u] = !par[u];
                end else if (zc[u] == mn[u] - 1) begin
                    sq[u][acc[u]] = HDB3_V;
                    if (!par[u]) sq[u][acc[u] - mn[u] + 1] = HDB3_B;
                    zc[u] = 0;
                    par[u] = 0;
                end else begin
                    sq[u][acc[u]] = HDB3_0;
                    zc[u]++;
                end
                acc[u]++;
                if (acc[u] > mn[u]) begin
                    s = sq[u][acc[u] - mn[u] - 1];
                    ev[u] = 1;
                    es[u] = s;
                    if (s == HDB3_1 || s == HDB3_B) begin
                        ep[u] = !lp[u]; en[u] = lp[u]; lp[u] = !lp[u];
                    end else if (s == HDB3_V) begin
                        ep[u] = lp[u]; en[u] = !lp[u];
                    end else begin
                        ep[u] = 0; en[u] = 0;
                    end
`ifdef HDBN_DEBUG_EN
                    etv[u] = (s == HDB3_V);
                    etb[u] = (s == HDB3_B);
`endif
                end else begin
                    ev[u] = 0; ep[u] = 0; en[u] = 0; es[u] = 2'b00;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 2; u++) begin
            chk("out_valid", u, {3'b0, ov[u]}, {3'b0, ev[u]});
            chk("code_p",    u, {3'b0, cp[u]}, {3'b0, ep[u]});
            chk("code_n",    u, {3'b0, cn[u]}, {3'b0, en[u]});
            chk("sym_type",  u, {2'b0, st[u]}, {2'b0, es[u]});
            chk("p_n_excl",  u, {3'b0, cp[u] & cn[u]}, 4'd0);
`ifdef HDBN_DEBUG_EN
            chk("test_add_v", u, {3'b0, tav[u]}, {3'b0, etv[u]});
            chk("test_add_b", u, {3'b0, tab[u]}, {3'b0, etb[u]});
`endif
            if (ov[u] === 1'b1 && lgn[u] < c_logsz) begin
                lg[u][lgn[u]] = {cp[u], cn[u], st[u]};
                lgn[u]++;
            end
        end
    endtask

    task automatic step(input bit v, input bit d);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
        model_step(v, d);
        check_all();
    endtask

    task automatic reset_cycle();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data_in  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        lgn[0] = 0;
        lgn[1] = 0;
        rst_n  = 1'b1;
    endtask

    // Feed bits (bit i = i-th symbol), optionally stalling after each, then flush
    task automatic run_seq(input logic [15:0] bits, input int len, input bit stall);
        for (int i = 0; i < len + 4; i++) begin
            step(1'b1, (i < len) ? bits[i] : 1'b0);
            if (stall) step(1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic compare_log(input string tag, input int u, input logic [3:0] exp [8], input int len);
        chk({tag, "_count"}, u, {3'b0, lgn[u] >= len}, 4'd1);
        for (int i = 0; i < len; i++) begin
            chk(tag, u, lg[u][i], exp[i]);
        end
    endtask

    // {code_p, code_n, sym_type}
    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] PM = 4'b1001;
    localparam logic [3:0] NM = 4'b0101;
    localparam logic [3:0] PB = 4'b1010;
    localparam logic [3:0] NB = 4'b0110;
    localparam logic [3:0] PV = 4'b1011;
    localparam logic [3:0] NV = 4'b0111;

    logic [3:0] e [8];

    initial begin
        mn[0] = 4;
        mn[1] = 3;
        lgn[0] = 0;
        lgn[1] = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = 1'b0;
        model_reset();

        // Reset state
        reset_cycle();
        reset_cycle();

        // 1,0,0,0,0 1: odd parity gives 000V
        run_seq(16'b0000_0000_0010_0001, 6, 1'b0);
        e = '{PM, Z, Z, Z, PV, NM, Z, Z};
        compare_log("scen_000v", 0, e, 6);

        // Eight zeros from reset: B00V pairs with alternating V
        reset_cycle();
        run_seq(16'b0, 8, 1'b0);
        e = '{PB, Z, Z, PV, NB, Z, Z, NV};
        compare_log("scen_b00v", 0, e, 8);

        // 1,1,0,0,0,0: even parity gives B00V
        reset_cycle();
        run_seq(16'b0000_0000_0000_0011, 6, 1'b0);
        e = '{PM, NM, PB, Z, Z, PV, Z, Z};
        compare_log("scen_even", 0, e, 6);

        // First stream with in_valid toggling
        reset_cycle();
        run_seq(16'b0000_0000_0010_0001, 6, 1'b1);
        e = '{PM, Z, Z, Z, PV, NM, Z, Z};
        compare_log("scen_stall", 0, e, 6);

        // Reset after 3 of 8 zeros, then 4 zeros
        reset_cycle();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        reset_cycle();
        reset_cycle();
        run_seq(16'b0, 4, 1'b0);
        e = '{PB, Z, Z, PV, Z, Z, Z, Z};
        compare_log("scen_rst", 0, e, 4);

        // N=3: 1 followed by six zeros
        reset_cycle();
        run_seq(16'b0000_0000_0000_0001, 7, 1'b0);
        e = '{PM, Z, Z, PV, NB, Z, NV, Z};
        compare_log("scen_n3", 1, e, 7);

        // Randomised traffic with zero-heavy data, stalls and occasional resets
        reset_cycle();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) reset_cycle();
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
